// File: rtl/iic_cfg_sequencer.sv
// Walks a (word_addr, data) register table and issues one I2C write per entry,
// with per-attempt timeout, bounded retry and an enforced idle gap between attempts.
module iic_cfg_sequencer #(
    parameter int         IDX_W      = 4,
    parameter logic [7:0] DEV_ADDR   = 8'hA0,
    parameter int         TIMEOUT    = 200000,
    parameter int         MAX_RETRY  = 3,
    parameter int         GAP_CYCLES = 1000
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W:0]   cfg_len,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [7:0]       tbl_word_addr,
    input  logic [7:0]       tbl_data,
    output logic             iic_send_en,
    output logic [7:0]       dev_addr,
    output logic [7:0]       word_addr,
    output logic [7:0]       write_data,
    input  logic             iic_done,
    output logic             busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [IDX_W-1:0] err_idx
);

    // One timer serves both the per-attempt timeout and the inter-attempt gap.
    localparam int TMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]  G_LAST = TW'(GAP_CYCLES - 2);
    localparam logic [3:0]     R_MAX  = 4'(MAX_RETRY);
    localparam logic [IDX_W:0] ONE_L  = (IDX_W + 1)'(1);

    typedef enum logic [2:0] {IDLE, FETCH, SEND, GAP, DONE, ERR} state_t;

    state_t           state, state_nx;
    logic [IDX_W:0]   len, len_nx;
    logic [IDX_W-1:0] idx_nx, err_idx_nx;
    logic [3:0]       retry, retry_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic [7:0]       word_addr_nx, write_data_nx;
    logic             en_nx, done_nx, err_nx, busy_nx;

    assign dev_addr = DEV_ADDR;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= IDLE;
            len         <= '0;
            tbl_idx     <= '0;
            retry       <= '0;
            timer       <= '0;
            word_addr   <= '0;
            write_data  <= '0;
            iic_send_en <= 1'b0;
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
            err_idx     <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            len         <= len_nx;
            tbl_idx     <= idx_nx;
            retry       <= retry_nx;
            timer       <= timer_nx;
            word_addr   <= word_addr_nx;
            write_data  <= write_data_nx;
            iic_send_en <= en_nx;
            cfg_done    <= done_nx;
            cfg_err     <= err_nx;
            err_idx     <= err_idx_nx;
            busy        <= busy_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        len_nx        = len;
        idx_nx        = tbl_idx;
        retry_nx      = retry;
        timer_nx      = timer;
        word_addr_nx  = word_addr;
        write_data_nx = write_data;
        en_nx         = iic_send_en;
        done_nx       = 1'b0;
        err_nx        = cfg_err;
        err_idx_nx    = err_idx;

        // Abort outranks everything, including a done pulse in the same cycle.
        if (abort && state != IDLE) begin
            state_nx = IDLE;
            en_nx    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_nx   = cfg_len;
                        idx_nx   = '0;
                        retry_nx = '0;
                        timer_nx = '0;
                        err_nx   = 1'b0;
                        state_nx = (cfg_len == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    word_addr_nx  = tbl_word_addr;
                    write_data_nx = tbl_data;
                    timer_nx      = '0;
                    en_nx         = 1'b1;
                    state_nx      = SEND;
                end
                SEND: begin
                    if (iic_done) begin
                        en_nx    = 1'b0;
                        timer_nx = '0;
                        if ({1'b0, tbl_idx} == len - ONE_L) begin
                            state_nx = DONE;
                        end else begin
                            idx_nx   = tbl_idx + IDX_W'(1);
                            retry_nx = '0;
                            state_nx = GAP;
                        end
                    end else if (timer == T_LAST) begin
                        en_nx    = 1'b0;
                        timer_nx = '0;
                        if (retry == R_MAX) begin
                            err_idx_nx = tbl_idx;
                            state_nx   = ERR;
                        end else begin
                            retry_nx = retry + 4'd1;
                            state_nx = GAP;
                        end
                    end else begin
                        timer_nx = timer + TW'(1);
                    end
                end
                // FETCH supplies the last low cycle, so GAP itself lasts GAP_CYCLES-1.
                GAP: begin
                    if (timer == G_LAST) begin
                        state_nx = FETCH;
                    end else begin
                        timer_nx = timer + TW'(1);
                    end
                end
                DONE: begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
                ERR: begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end

        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_iic_cfg_sequencer.sv
// Directed bench for iic_cfg_sequencer with a scripted write-engine model
// and a monitor that records every iic_send_en window.
module tb_iic_cfg_sequencer;

    localparam int IDX_W = 4;

    logic             sys_clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [IDX_W:0]   cfg_len = '0;
    logic [IDX_W-1:0] tbl_idx;
    logic [7:0]       tbl_word_addr, tbl_data;
    logic             iic_send_en;
    logic [7:0]       dev_addr, word_addr, write_data;
    logic             iic_done = 1'b0;
    logic             busy, cfg_done, cfg_err;
    logic [IDX_W-1:0] err_idx;

    logic [7:0] wa_mem [16];
    logic [7:0] wd_mem [16];

    int errors = 0;
    int checks = 0;

    // Engine script: one entry per en window; 0 means never answer.
    int plan [$];

    int win_wa [$];
    int win_wd [$];
    int win_len [$];
    int gap_len [$];
    int done_cnt = 0;
    bit mon_seen = 1'b0;

    assign tbl_word_addr = wa_mem[tbl_idx];
    assign tbl_data      = wd_mem[tbl_idx];

    always #5 sys_clk = ~sys_clk;

    iic_cfg_sequencer #(
        .IDX_W(IDX_W), .DEV_ADDR(8'hA0), .TIMEOUT(50), .MAX_RETRY(2), .GAP_CYCLES(4)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .start(start), .abort(abort), .cfg_len(cfg_len),
        .tbl_idx(tbl_idx), .tbl_word_addr(tbl_word_addr), .tbl_data(tbl_data),
        .iic_send_en(iic_send_en), .dev_addr(dev_addr), .word_addr(word_addr),
        .write_data(write_data), .iic_done(iic_done), .busy(busy), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .err_idx(err_idx)
    );

    // Write-engine model: pulses iic_done on the Nth cycle of an en window.
    initial begin : engine
        bit e_prev;
        int e_hi;
        int cur_delay;
        e_prev = 1'b0;
        e_hi = 0;
        cur_delay = 0;
        forever begin
            @(negedge sys_clk);
            if (iic_send_en) begin
                if (!e_prev) begin
                    if (plan.size() > 0) cur_delay = plan.pop_front();
                    else cur_delay = 0;
                    e_hi = 0;
                end
                e_hi++;
                iic_done = (cur_delay != 0 && e_hi == cur_delay);
            end else begin
                iic_done = 1'b0;
            end
            e_prev = iic_send_en;
        end
    end

    initial begin : monitor
        bit prev_en;
        int hi;
        int lo;
        prev_en = 1'b0;
        hi = 0;
        lo = 0;
        forever begin
            @(negedge sys_clk);
            if (iic_send_en) begin
                if (!prev_en) begin
                    win_wa.push_back(int'(word_addr));
                    win_wd.push_back(int'(write_data));
                    if (mon_seen) gap_len.push_back(lo);
                    mon_seen = 1'b1;
                end
                hi++;
                lo = 0;
            end else begin
                if (prev_en) win_len.push_back(hi);
                hi = 0;
                lo++;
            end
            if (cfg_done) done_cnt++;
            prev_en = iic_send_en;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_monitor();
        win_wa.delete();
        win_wd.delete();
        win_len.delete();
        gap_len.delete();
        done_cnt = 0;
        mon_seen = 1'b0;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Pulses start for one cycle; returns one cycle after the accepting edge.
    task automatic apply_stimulus(input int len);
        clear_monitor();
        cfg_len = (IDX_W + 1)'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_output({tag, "_idle"}, 32'(busy), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            wa_mem[i] = 8'h10 + 8'(i);
            wd_mem[i] = 8'hAA + 8'(i * 17);
        end

        // Reset values
        repeat (3) tick();
        rst = 1'b0;
        check_output("rst_en", 32'(iic_send_en), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_done", 32'(cfg_done), 0);
        check_output("rst_err", 32'(cfg_err), 0);
        check_output("rst_idx", 32'(tbl_idx), 0);
        check_output("rst_wa", 32'(word_addr), 0);
        check_output("dev_addr", 32'(dev_addr), 32'hA0);

        // 1: three clean writes
        plan = '{20, 20, 20};
        apply_stimulus(3);
        check_output("t1_busy_after_start", 32'(busy), 1);
        check_output("t1_en_fetch", 32'(iic_send_en), 0);
        tick();
        check_output("t1_en_rise", 32'(iic_send_en), 1);
        wait_idle(400, "t1");
        check_output("t1_windows", 32'(win_wa.size()), 3);
        check_output("t1_wa0", 32'(win_wa[0]), 32'h10);
        check_output("t1_wd0", 32'(win_wd[0]), 32'hAA);
        check_output("t1_wa1", 32'(win_wa[1]), 32'h11);
        check_output("t1_wd1", 32'(win_wd[1]), 32'hBB);
        check_output("t1_wa2", 32'(win_wa[2]), 32'h12);
        check_output("t1_wd2", 32'(win_wd[2]), 32'hCC);
        check_output("t1_len0", 32'(win_len[0]), 20);
        check_output("t1_gap0", 32'(gap_len[0]), 4);
        check_output("t1_gap1", 32'(gap_len[1]), 4);
        check_output("t1_done_cnt", 32'(done_cnt), 1);
        check_output("t1_err", 32'(cfg_err), 0);
        check_output("t1_tbl_idx", 32'(tbl_idx), 2);

        // 2: zero-length run
        apply_stimulus(0);
        check_output("t2_busy", 32'(busy), 1);
        check_output("t2_done_early", 32'(cfg_done), 0);
        tick();
        check_output("t2_done", 32'(cfg_done), 1);
        check_output("t2_busy_low", 32'(busy), 0);
        tick();
        check_output("t2_done_once", 32'(cfg_done), 0);
        check_output("t2_no_window", 32'(win_wa.size()), 0);

        // 3: entry 1 never answers
        plan = '{20, 0, 0, 0};
        apply_stimulus(3);
        wait_idle(600, "t3");
        check_output("t3_windows", 32'(win_wa.size()), 4);
        check_output("t3_wa1", 32'(win_wa[1]), 32'h11);
        check_output("t3_wa3", 32'(win_wa[3]), 32'h11);
        check_output("t3_len1", 32'(win_len[1]), 50);
        check_output("t3_len3", 32'(win_len[3]), 50);
        check_output("t3_err", 32'(cfg_err), 1);
        check_output("t3_err_idx", 32'(err_idx), 1);
        check_output("t3_no_done", 32'(done_cnt), 0);

        // 4: entry 0 retried once, entry 1 uses all three attempts
        plan = '{0, 20, 0, 0, 20};
        apply_stimulus(2);
        check_output("t4_err_cleared", 32'(cfg_err), 0);
        wait_idle(800, "t4");
        check_output("t4_windows", 32'(win_wa.size()), 5);
        check_output("t4_wa1", 32'(win_wa[1]), 32'h10);
        check_output("t4_wa4", 32'(win_wa[4]), 32'h11);
        check_output("t4_len0", 32'(win_len[0]), 50);
        check_output("t4_len4", 32'(win_len[4]), 20);
        check_output("t4_done_cnt", 32'(done_cnt), 1);
        check_output("t4_err", 32'(cfg_err), 0);

        // 5: done coincides with the last timeout cycle; start while busy
        plan = '{50, 20};
        apply_stimulus(2);
        repeat (10) tick();
        cfg_len = (IDX_W + 1)'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("t5_en_held", 32'(iic_send_en), 1);
        wait_idle(400, "t5");
        check_output("t5_windows", 32'(win_wa.size()), 2);
        check_output("t5_len0", 32'(win_len[0]), 50);
        check_output("t5_wa1", 32'(win_wa[1]), 32'h11);
        check_output("t5_tbl_idx", 32'(tbl_idx), 1);
        check_output("t5_done_cnt", 32'(done_cnt), 1);
        check_output("t5_err", 32'(cfg_err), 0);

        // 6a: abort during entry 2
        plan = '{20, 20, 0};
        apply_stimulus(3);
        begin
            int n;
            n = 0;
            while (!(iic_send_en === 1'b1 && tbl_idx == 2) && n < 300) begin
                tick();
                n++;
            end
            check_output("t6_reach_entry2", 32'(n < 300), 1);
        end
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("t6_abort_en", 32'(iic_send_en), 0);
        check_output("t6_abort_busy", 32'(busy), 0);
        check_output("t6_abort_idx", 32'(tbl_idx), 2);
        check_output("t6_abort_err_idx", 32'(err_idx), 1);
        repeat (3) tick();
        check_output("t6_abort_no_done", 32'(done_cnt), 0);
        check_output("t6_abort_no_err", 32'(cfg_err), 0);

        // 6b: reset during GAP
        plan = '{20, 20, 20};
        apply_stimulus(3);
        begin
            int n;
            n = 0;
            while (win_len.size() == 0 && n < 100) begin
                tick();
                n++;
            end
            check_output("t6_reach_gap", 32'(n < 100), 1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("t6_rst_en", 32'(iic_send_en), 0);
        check_output("t6_rst_busy", 32'(busy), 0);
        check_output("t6_rst_idx", 32'(tbl_idx), 0);
        check_output("t6_rst_err_idx", 32'(err_idx), 0);
        check_output("t6_rst_wa", 32'(word_addr), 0);
        check_output("t6_rst_wd", 32'(write_data), 0);
        check_output("t6_rst_done", 32'(cfg_done), 0);
        check_output("t6_rst_err", 32'(cfg_err), 0);
        repeat (10) tick();
        check_output("t6_rst_quiet", 32'(win_wa.size()), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
